// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, SPI mode constants and counter-width helper
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int CPOL = 0;
  localparam int CPHA = 0;
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period counter producing a one-cycle tick every CLKDIV enabled cycles
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic i_clk,
  input  logic i_arstn,
  input  logic i_en,
  output logic o_tick
);
  localparam int W = cnt_w(CLKDIV);
  logic [W-1:0] cnt;
  assign o_tick = i_en && cnt == W'(CLKDIV - 1);
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) cnt <= '0;
    else cnt <= (!i_en || o_tick) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/spi_controller.sv
// spi_controller: mode-0 SPI master, one DATA_W-bit full-duplex frame per request
// Optional SPI_CONTROLLER_CSN_EN adds active-low chip select o_csn.
module spi_controller
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CLKDIV = 4
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  input  logic              i_txValid,
  output logic              o_txReady,
  input  logic [DATA_W-1:0] i_txData,
  output logic              o_rxValid,
  output logic [DATA_W-1:0] o_rxData,
  output logic              o_busy,
  output logic              o_sck,
  output logic              o_sdo,
`ifdef SPI_CONTROLLER_CSN_EN
  output logic              o_csn,
`endif
  input  logic              i_sdi
);
  localparam int BW = cnt_w(DATA_W + 1);
  state_t state, state_nxt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [BW-1:0] bit_cnt;
  logic tick, accept, lead, trail, sample, shift, last;
  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .i_clk  (i_clk),
    .i_arstn(i_arstn),
    .i_en   (state == SHIFT),
    .o_tick (tick)
  );
  // leading edge leaves the idle level; mode 0 samples on it and shifts on the trailing one
  assign lead   = tick && o_sck == 1'(CPOL);
  assign trail  = tick && o_sck != 1'(CPOL);
  assign sample = CPHA == 0 ? lead : trail;
  assign shift  = CPHA == 0 ? trail : lead;
  assign accept = state == IDLE && i_txValid;
  assign last   = shift && bit_cnt + 1'b1 == BW'(DATA_W);
  assign o_txReady = state == IDLE;
  assign o_busy    = state != IDLE;
  assign o_rxValid = state == DONE;
`ifdef SPI_CONTROLLER_CSN_EN
  assign o_csn = state == IDLE;
`endif
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (i_txValid ? SHIFT : IDLE) :
                state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      o_sck    <= 1'(CPOL);
      o_sdo    <= 1'b0;
      o_rxData <= '0;
    end else if (accept) begin
      tx_sh   <= i_txData;
      o_sdo   <= i_txData[DATA_W-1];
      bit_cnt <= '0;
      o_sck   <= 1'(CPOL);
    end else if (sample) begin
      o_sck <= ~o_sck;
      rx_sh <= {rx_sh[DATA_W-2:0], i_sdi};
    end else if (shift) begin
      o_sck   <= ~o_sck;
      tx_sh   <= tx_sh << 1;
      o_sdo   <= last ? 1'b0 : tx_sh[DATA_W-2];
      bit_cnt <= bit_cnt + 1'b1;
      if (last) o_rxData <= rx_sh;
    end
  end
endmodule
